// File: rtl/nios2_subsystem_sample_fifo_pkg.sv
// Register map constants and command decode shared by the sample FIFO reader.
package nios2_subsystem_sample_fifo_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_CMD    = 2'd3;

   localparam int STATUS_EMPTY_BIT = 16;
   localparam int STATUS_FULL_BIT  = 17;
   localparam int STATUS_OVF_BIT   = 18;
   localparam int STATUS_UNF_BIT   = 19;

   localparam int DATA_VALID_BIT   = 31;
   localparam int CTRL_IRQ_EN_BIT  = 0;
   localparam int CTRL_THRESH_LSB  = 8;

   localparam int CMD_CLR_OVF_BIT  = 0;
   localparam int CMD_CLR_UNF_BIT  = 1;
   localparam int CMD_FLUSH_BIT    = 2;

   // Field order matches writedata[2:0] so a cast decodes the command word.
   typedef struct packed {
      logic flush;
      logic clr_unf;
      logic clr_ovf;
   } cmd_t;

endpackage

// File: rtl/nios2_subsystem_sync_fifo.sv
// Show-ahead synchronous FIFO; push/pop are pre-qualified by the caller, flush wins.
module nios2_subsystem_sync_fifo #(
   parameter int WIDTH      = 24,
   parameter int DEPTH_LOG2 = 6
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  pop,
   input  logic                  flush,
   output logic [WIDTH-1:0]      head,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  full,
   output logic                  empty
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr;
   logic [DEPTH_LOG2-1:0] rptr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (push) wptr <= wptr + DEPTH_LOG2'(1);
         if (pop)  rptr <= rptr + DEPTH_LOG2'(1);
         if (push && !pop)      level <= level + (DEPTH_LOG2+1)'(1);
         else if (pop && !push) level <= level - (DEPTH_LOG2+1)'(1);
      end
   end

   // When full, push+pop writes the slot being read; head sees the old word this cycle.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wptr] <= wdata;
   end

   assign head  = mem[rptr];
   assign full  = level[DEPTH_LOG2];
   assign empty = (level == '0);

endmodule

// File: rtl/nios2_subsystem_sample_fifo_reader.sv
// Avalon-MM slave exposing a sample FIFO: pop-on-read DATA, STATUS, CTRL, CMD and a level irq.
module nios2_subsystem_sample_fifo_reader
   import nios2_subsystem_sample_fifo_pkg::*;
#(
   parameter int SAMPLE_W   = 24,
   parameter int DEPTH_LOG2 = 6
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [1:0]          address,
   input  logic                chipselect,
   input  logic                read_n,
   input  logic                write_n,
   input  logic [31:0]         writedata,
   output logic [31:0]         readdata,
   output logic                irq,
   input  logic [SAMPLE_W-1:0] in_sample,
   input  logic                in_valid
);

   logic                  rd, wr;
   cmd_t                  cmd;
   logic                  pop, push, ovf_set, unf_set;
   logic [SAMPLE_W-1:0]   head;
   logic [DEPTH_LOG2:0]   level;
   logic                  full, empty;
   logic                  irq_en;
   logic [DEPTH_LOG2:0]   threshold;
   logic                  ovf, unf;
   logic [31:0]           rd_mux;
   logic                  unused_wdata;

   assign rd  = chipselect & ~read_n;
   assign wr  = chipselect & ~write_n;
   assign cmd = (wr && address == ADDR_CMD) ? cmd_t'(writedata[2:0]) : '0;

   assign pop     = rd && address == ADDR_DATA && !empty && !cmd.flush;
   assign push    = in_valid && (!full || pop) && !cmd.flush;
   assign ovf_set = in_valid && full && !pop && !cmd.flush;
   assign unf_set = rd && address == ADDR_DATA && empty;

   assign unused_wdata = ^writedata;

   nios2_subsystem_sync_fifo #(
      .WIDTH      (SAMPLE_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .wdata   (in_sample),
      .pop     (pop),
      .flush   (cmd.flush),
      .head    (head),
      .level   (level),
      .full    (full),
      .empty   (empty)
   );

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA: begin
            if (!empty) begin
               rd_mux[DATA_VALID_BIT] = 1'b1;
               rd_mux[SAMPLE_W-1:0]   = head;
            end
         end
         ADDR_STATUS: begin
            rd_mux[DEPTH_LOG2:0]     = level;
            rd_mux[STATUS_EMPTY_BIT] = empty;
            rd_mux[STATUS_FULL_BIT]  = full;
            rd_mux[STATUS_OVF_BIT]   = ovf;
            rd_mux[STATUS_UNF_BIT]   = unf;
         end
         ADDR_CTRL: begin
            rd_mux[CTRL_IRQ_EN_BIT]                    = irq_en;
            rd_mux[CTRL_THRESH_LSB +: DEPTH_LOG2+1]    = threshold;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata  <= '0;
         irq_en    <= 1'b0;
         threshold <= '0;
         ovf       <= 1'b0;
         unf       <= 1'b0;
         irq       <= 1'b0;
      end else begin
         if (rd) readdata <= rd_mux;
         if (wr && address == ADDR_CTRL) begin
            irq_en    <= writedata[CTRL_IRQ_EN_BIT];
            threshold <= writedata[CTRL_THRESH_LSB +: DEPTH_LOG2+1];
         end
         // Set beats clear when both land in the same cycle.
         ovf <= ovf_set | (ovf & ~cmd.clr_ovf);
         unf <= unf_set | (unf & ~cmd.clr_unf);
         irq <= irq_en && (threshold != '0) && (level >= threshold);
      end
   end

endmodule

// File: tb/tb_nios2_subsystem_sample_fifo_reader.sv
// Scoreboard bench for the sample FIFO reader: queue model of pushed samples vs DATA reads.
module tb_nios2_subsystem_sample_fifo_reader;

   localparam int SW    = 24;
   localparam int DL    = 6;
   localparam int DEPTH = 64;

   logic          clk;
   logic          reset_n;
   logic [1:0]    address;
   logic          chipselect;
   logic          read_n;
   logic          write_n;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic          irq;
   logic [SW-1:0] in_sample;
   logic          in_valid;

   int vectors     = 0;
   int miscompares = 0;
   logic [SW-1:0] sb[$];

   nios2_subsystem_sample_fifo_reader #(.SAMPLE_W(SW), .DEPTH_LOG2(DL)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .read_n     (read_n),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq),
      .in_sample  (in_sample),
      .in_valid   (in_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] sb_pop();
      if (sb.size() == 0) return 32'h0;
      return {1'b1, 7'b0, sb.pop_front()};
   endfunction

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      address = a; chipselect = 1'b1; read_n = 1'b0;
      @(negedge clk);
      d = readdata; chipselect = 1'b0; read_n = 1'b1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
      @(negedge clk);
      address = a; writedata = v; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic push(input logic [SW-1:0] s);
      @(negedge clk);
      in_sample = s; in_valid = 1'b1;
      if (sb.size() < DEPTH) sb.push_back(s);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset_n = 1'b0; address = '0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
      writedata = '0; in_sample = '0; in_valid = 1'b0;
      repeat (3) @(negedge clk);
      vectors++; if (readdata !== 32'h0) begin miscompares++; $display("FAIL reset_readdata: got %h expected 00000000", readdata); end
      vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b expected 0", irq); end
      reset_n = 1'b1;
      bus_read(2'd1, d);
      vectors++; if (d !== 32'h0001_0000) begin miscompares++; $display("FAIL reset_status: got %h expected 00010000", d); end
      bus_read(2'd2, d);
      vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL reset_ctrl: got %h expected 00000000", d); end
   endtask

   task automatic test_basic();
      logic [31:0] d, e;
      push(24'h000123);
      push(24'h000456);
      bus_read(2'd1, d);
      vectors++; if (d !== 32'h0000_0002) begin miscompares++; $display("FAIL basic_level2: got %h expected 00000002", d); end
      for (int i = 0; i < 2; i++) begin
         e = sb_pop();
         bus_read(2'd0, d);
         vectors++; if (d !== e) begin miscompares++; $display("FAIL basic_data%0d: got %h expected %h", i, d, e); end
      end
      bus_read(2'd1, d);
      vectors++; if (d !== 32'h0001_0000) begin miscompares++; $display("FAIL basic_empty: got %h expected 00010000", d); end
   endtask

   task automatic test_underflow();
      logic [31:0] d;
      bus_read(2'd0, d);
      vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL unf_data: got %h expected 00000000", d); end
      bus_read(2'd1, d);
      vectors++; if (d !== 32'h0009_0000) begin miscompares++; $display("FAIL unf_status: got %h expected 00090000", d); end
      bus_write(2'd3, 32'h2);
      bus_read(2'd1, d);
      vectors++; if (d !== 32'h0001_0000) begin miscompares++; $display("FAIL unf_clear: got %h expected 00010000", d); end
   endtask

   task automatic test_overflow();
      logic [31:0] d, e;
      for (int i = 0; i < DEPTH + 1; i++) push(SW'(24'h100 + i));
      bus_read(2'd1, d);
      vectors++; if (d !== 32'h0006_0040) begin miscompares++; $display("FAIL ovf_status: got %h expected 00060040", d); end
      bus_write(2'd3, 32'h1);
      bus_read(2'd1, d);
      vectors++; if (d !== 32'h0002_0040) begin miscompares++; $display("FAIL ovf_clear: got %h expected 00020040", d); end
      // Push and pop in the same cycle while full.
      @(negedge clk);
      address = 2'd0; chipselect = 1'b1; read_n = 1'b0; in_sample = 24'hABCDE; in_valid = 1'b1;
      e = sb_pop(); sb.push_back(24'hABCDE);
      @(negedge clk);
      d = readdata; chipselect = 1'b0; read_n = 1'b1; in_valid = 1'b0;
      vectors++; if (d !== e) begin miscompares++; $display("FAIL full_pushpop_data: got %h expected %h", d, e); end
      bus_read(2'd1, d);
      vectors++; if (d !== 32'h0002_0040) begin miscompares++; $display("FAIL full_pushpop_status: got %h expected 00020040", d); end
      for (int i = 0; i < DEPTH; i++) begin
         e = sb_pop();
         bus_read(2'd0, d);
         vectors++; if (d !== e) begin miscompares++; $display("FAIL drain%0d: got %h expected %h", i, d, e); end
      end
      bus_read(2'd1, d);
      vectors++; if (d !== 32'h0001_0000) begin miscompares++; $display("FAIL drain_status: got %h expected 00010000", d); end
   endtask

   task automatic test_irq();
      logic [31:0] d, e;
      bus_write(2'd2, 32'hFFFF_FFFF);
      bus_read(2'd2, d);
      vectors++; if (d !== 32'h0000_7F01) begin miscompares++; $display("FAIL ctrl_mask: got %h expected 00007f01", d); end
      bus_write(2'd2, 32'h0000_0401);
      for (int i = 0; i < 3; i++) push(SW'(24'h200 + i));
      @(negedge clk);
      vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_lvl3: got %b expected 0", irq); end
      push(24'h203);
      vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_lag_rise: got %b expected 0", irq); end
      @(negedge clk);
      vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_rise: got %b expected 1", irq); end
      e = sb_pop();
      bus_read(2'd0, d);
      vectors++; if (d !== e) begin miscompares++; $display("FAIL irq_pop_data: got %h expected %h", d, e); end
      vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_lag_fall: got %b expected 1", irq); end
      @(negedge clk);
      vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_fall: got %b expected 0", irq); end
      bus_write(2'd2, 32'h0);
      for (int i = 0; i < 3; i++) begin
         e = sb_pop();
         bus_read(2'd0, d);
         vectors++; if (d !== e) begin miscompares++; $display("FAIL irq_drain%0d: got %h expected %h", i, d, e); end
      end
   endtask

   task automatic test_flush();
      logic [31:0] d, e;
      bus_read(2'd0, d);
      for (int i = 0; i < 10; i++) push(SW'(24'h300 + i));
      bus_read(2'd1, d);
      vectors++; if (d !== 32'h0008_000A) begin miscompares++; $display("FAIL flush_pre: got %h expected 0008000a", d); end
      @(negedge clk);
      address = 2'd3; writedata = 32'h4; chipselect = 1'b1; write_n = 1'b0;
      in_sample = 24'hFFFFFF; in_valid = 1'b1;
      sb.delete();
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1; in_valid = 1'b0;
      bus_read(2'd1, d);
      vectors++; if (d !== 32'h0009_0000) begin miscompares++; $display("FAIL flush_post: got %h expected 00090000", d); end
      push(24'h000777);
      e = sb_pop();
      bus_read(2'd0, d);
      vectors++; if (d !== e) begin miscompares++; $display("FAIL flush_repush: got %h expected %h", d, e); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d, e;
      bus_write(2'd2, 32'h0000_0201);
      for (int i = 0; i < 5; i++) push(SW'(24'h400 + i));
      @(negedge clk);
      vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL mid_irq_pre: got %b expected 1", irq); end
      @(negedge clk);
      address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
      e = sb_pop();
      @(posedge clk);
      #2;
      vectors++; if (readdata !== e) begin miscompares++; $display("FAIL mid_inflight: got %h expected %h", readdata, e); end
      reset_n = 1'b0;
      #1;
      vectors++; if (readdata !== 32'h0) begin miscompares++; $display("FAIL mid_readdata: got %h expected 00000000", readdata); end
      vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL mid_irq: got %b expected 0", irq); end
      chipselect = 1'b0; read_n = 1'b1;
      sb.delete();
      @(negedge clk);
      reset_n = 1'b1;
      bus_read(2'd1, d);
      vectors++; if (d !== 32'h0001_0000) begin miscompares++; $display("FAIL mid_status: got %h expected 00010000", d); end
      bus_read(2'd2, d);
      vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL mid_ctrl: got %h expected 00000000", d); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_underflow();
      test_overflow();
      test_irq();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
